// File: rtl/padded_window_reader.sv
// Streams 3x3x3 int8 windows (ch4/ch5/ch6) out of three zero-padded (DIM+2)^2 buffers.
// Optional macro WINDOW_REUSE_EN reuses the kx=1,2 taps of the previous column.
module padded_window_reader #(
  parameter int unsigned DIM = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [14:0]       rd_addr,
  input  logic signed [7:0] rd_data_ch4,
  input  logic signed [7:0] rd_data_ch5,
  input  logic signed [7:0] rd_data_ch6,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [215:0]      win_data,
  output logic [6:0]        win_row,
  output logic [6:0]        win_col,
  output logic              busy,
  output logic              done
);
  localparam logic [14:0] PITCH = 15'(DIM + 2);
  localparam logic [6:0]  LAST  = 7'(DIM - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    OUT     = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t      state_q;
  logic [6:0]  row_q, col_q;
  logic [1:0]  ky_q, kx_q;
  logic        cap_en_q;
  logic [3:0]  cap_k_q;
  logic [7:0]  taps_q [27];
  logic        rd_en_q, win_valid_q, busy_q, done_q;
  logic [14:0] rd_addr_q;
  logic [6:0]  nxt_row_d, nxt_col_d;
  logic        reuse_s;

`ifdef WINDOW_REUSE_EN
  assign reuse_s = 1'b1;
`else
  assign reuse_s = 1'b0;
`endif

  function automatic logic [14:0] tap_addr(input logic [6:0] r, input logic [6:0] c,
                                           input logic [1:0] ky, input logic [1:0] kx);
    return (15'(r) + 15'(ky)) * PITCH + 15'(c) + 15'(kx);
  endfunction

  // With reuse, every column but the first only needs its rightmost tap column.
  function automatic logic [1:0] first_kx(input logic reuse, input logic [6:0] c);
    return (reuse && (c != 7'd0)) ? 2'd2 : 2'd0;
  endfunction

  // Raster position that follows the current window.
  always_comb begin
    nxt_row_d = row_q;
    nxt_col_d = col_q;
    if (col_q == LAST) begin
      nxt_row_d = row_q + 7'd1;
      nxt_col_d = 7'd0;
    end else begin
      nxt_row_d = row_q;
      nxt_col_d = col_q + 7'd1;
    end
  end

  // Frame FSM, read issue, delayed tap capture and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= 7'd0;
      col_q       <= 7'd0;
      ky_q        <= 2'd0;
      kx_q        <= 2'd0;
      cap_en_q    <= 1'b0;
      cap_k_q     <= 4'd0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= 15'd0;
      win_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 27; i++) begin
        taps_q[i] <= 8'd0;
      end
    end else begin
      cap_en_q <= rd_en_q;
      cap_k_q  <= 4'(ky_q) * 4'd3 + 4'(kx_q);
      done_q   <= 1'b0;
      if (cap_en_q) begin
        taps_q[5'(cap_k_q)]          <= rd_data_ch4;
        taps_q[5'(cap_k_q) + 5'd9]   <= rd_data_ch5;
        taps_q[5'(cap_k_q) + 5'd18]  <= rd_data_ch6;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            row_q     <= 7'd0;
            col_q     <= 7'd0;
            busy_q    <= 1'b1;
            ky_q      <= 2'd0;
            kx_q      <= 2'd0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= tap_addr(7'd0, 7'd0, 2'd0, 2'd0);
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          if (ky_q == 2'd2 && kx_q == 2'd2) begin
            rd_en_q <= 1'b0;
            state_q <= CAPTURE;
          end else if (kx_q == 2'd2) begin
            ky_q      <= ky_q + 2'd1;
            kx_q      <= first_kx(reuse_s, col_q);
            rd_addr_q <= tap_addr(row_q, col_q, ky_q + 2'd1, first_kx(reuse_s, col_q));
          end else begin
            kx_q      <= kx_q + 2'd1;
            rd_addr_q <= tap_addr(row_q, col_q, ky_q, kx_q + 2'd1);
          end
        end
        CAPTURE: begin
          win_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (win_ready) begin
            win_valid_q <= 1'b0;
            if (row_q == LAST && col_q == LAST) begin
              row_q   <= 7'd0;
              col_q   <= 7'd0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              row_q     <= nxt_row_d;
              col_q     <= nxt_col_d;
              ky_q      <= 2'd0;
              kx_q      <= first_kx(reuse_s, nxt_col_d);
              rd_en_q   <= 1'b1;
              rd_addr_q <= tap_addr(nxt_row_d, nxt_col_d, 2'd0, first_kx(reuse_s, nxt_col_d));
              state_q   <= FETCH;
`ifdef WINDOW_REUSE_EN
              // Slide every (ch,ky) row of taps one column left; kx=2 is refetched.
              if (nxt_col_d != 7'd0) begin
                for (int t = 0; t < 9; t++) begin
                  taps_q[5'(t * 3)]     <= taps_q[5'(t * 3 + 1)];
                  taps_q[5'(t * 3 + 1)] <= taps_q[5'(t * 3 + 2)];
                end
              end
`endif
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < 27; g++) begin : g_win
    assign win_data[g*8 +: 8] = taps_q[g];
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign win_valid = win_valid_q;
  assign win_row   = row_q;
  assign win_col   = col_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_padded_window_reader.sv
// Self-checking bench for padded_window_reader: 128x128 instance plus an 8x8 instance for a full frame.
module tb_padded_window_reader;
  localparam int NPIX = 16900;
`ifdef WINDOW_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  typedef struct {
    int          k;
    logic [14:0] addr;
  } fetch_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, win_ready, rd_en, win_valid, busy, done;
  logic [14:0] rd_addr;
  logic signed [7:0] d4 = 8'sd0, d5 = 8'sd0, d6 = 8'sd0;
  logic [215:0] win_data;
  logic [6:0] win_row, win_col;

  logic s_start, s_ready, s_rd_en, s_valid, s_busy, s_done;
  logic [14:0] s_rd_addr;
  logic signed [7:0] s4 = 8'sd0, s5 = 8'sd0, s6 = 8'sd0;
  logic [215:0] s_data;
  logic [6:0] s_row, s_col;

  logic [7:0] mem4 [NPIX];
  logic [7:0] mem5 [NPIX];
  logic [7:0] mem6 [NPIX];
  fetch_vec_t tbl [9];

  int checks = 0, errors = 0;
  int exp_r = 0, exp_c = 0, hs = 0, dn = 0;
  int s_exp_r = 0, s_exp_c = 0, s_hs = 0, s_dn = 0, s_max_addr = 0;
  logic [14:0] iss [$];

  padded_window_reader u_dut (
    .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data_ch4(d4), .rd_data_ch5(d5), .rd_data_ch6(d6),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
  );

  padded_window_reader #(.DIM(8)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .rd_data_ch4(s4), .rd_data_ch5(s5), .rd_data_ch6(s6),
    .win_valid(s_valid), .win_ready(s_ready), .win_data(s_data),
    .win_row(s_row), .win_col(s_col), .busy(s_busy), .done(s_done)
  );

  // Buffer model: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en) begin
      d4 <= mem4[rd_addr];
      d5 <= mem5[rd_addr];
      d6 <= mem6[rd_addr];
    end
    if (s_rd_en) begin
      s4 <= mem4[s_rd_addr];
      s5 <= mem5[s_rd_addr];
      s6 <= mem6[s_rd_addr];
    end
  end

  function automatic logic [215:0] exp_win(input int r, input int c, input int pitch);
    logic [215:0] w = '0;
    int a;
    for (int ch = 0; ch < 3; ch++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++) begin
          a = (r + ky) * pitch + c + kx;
          w[(ch*9 + ky*3 + kx)*8 +: 8] = (ch == 0) ? mem4[a] : ((ch == 1) ? mem5[a] : mem6[a]);
        end
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [215:0] act, input logic [215:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the 128x128 instance: coordinates, window contents and issued addresses.
  initial begin : mon_main
    int n, first;
    forever begin
      @(negedge clk);
      if (rst) begin
        iss.delete();
        exp_r = 0;
        exp_c = 0;
      end else begin
        if (rd_en) iss.push_back(rd_addr);
        if (done) dn++;
        if (win_valid && win_ready) begin
          chk("win_row", win_row, exp_r);
          chk("win_col", win_col, exp_c);
          chkw("win_data", win_data, exp_win(exp_r, exp_c, 130));
          first = (REUSE && exp_c > 0) ? 2 : 0;
          chk("fetch_count", iss.size(), (3 - first) * 3);
          n = 0;
          for (int ky = 0; ky < 3; ky++)
            for (int kx = first; kx < 3; kx++) begin
              if (n < iss.size()) chk("fetch_addr", iss[n], (exp_r + ky) * 130 + exp_c + kx);
              n++;
            end
          iss.delete();
          hs++;
          exp_c++;
          if (exp_c == 128) begin
            exp_c = 0;
            exp_r++;
          end
        end
      end
    end
  end

  // Scoreboard for the 8x8 instance used for whole-frame behaviour.
  initial begin : mon_small
    forever begin
      @(negedge clk);
      if (rst) begin
        s_exp_r = 0;
        s_exp_c = 0;
      end else begin
        if (s_rd_en && int'(s_rd_addr) > s_max_addr) s_max_addr = int'(s_rd_addr);
        if (s_done) begin
          s_dn++;
          chk("fin_busy", s_busy, 0);
        end
        if (s_valid && s_ready) begin
          chk("s_win_row", s_row, s_exp_r);
          chk("s_win_col", s_col, s_exp_c);
          chkw("s_win_data", s_data, exp_win(s_exp_r, s_exp_c, 10));
          s_hs++;
          s_exp_c++;
          if (s_exp_c == 8) begin
            s_exp_c = 0;
            s_exp_r++;
          end
        end
      end
    end
  end

  initial begin : stim
    int lat, cyc, base;
    rst = 1'b1;
    start = 1'b0;
    win_ready = 1'b0;
    s_start = 1'b0;
    s_ready = 1'b0;
    tbl = '{'{0, 15'd0}, '{1, 15'd1}, '{2, 15'd2}, '{3, 15'd130}, '{4, 15'd131},
            '{5, 15'd132}, '{6, 15'd260}, '{7, 15'd261}, '{8, 15'd262}};
    for (int a = 0; a < NPIX; a++) begin
      mem4[a] = a[7:0];
      mem5[a] = 8'($urandom);
      mem6[a] = 8'($urandom);
    end
    repeat (3) tick();

    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_win_valid", win_valid, 0);
    chkw("rst_win_data", win_data, '0);
    chk("rst_win_row", win_row, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    repeat (2) tick();

    // First window: address order, latency, ch4 taps equal addr[7:0].
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 9; i++) begin
      chk("fetch_rd_en", rd_en, 1);
      chk("fetch_addr_tbl", rd_addr, tbl[i].addr);
      tick();
      lat++;
    end
    chk("capture_rd_en", rd_en, 0);
    chk("capture_valid", win_valid, 0);
    while (!win_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("latency", lat, 11);
    chk("first_row", win_row, 0);
    chk("first_col", win_col, 0);
    for (int i = 0; i < 9; i++) chk("tap_ch4", win_data[tbl[i].k*8 +: 8], tbl[i].addr[7:0]);

    // Back-pressure: window held, no reads.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_valid", win_valid, 1);
      chk("hold_rd_en", rd_en, 0);
      chkw("hold_data", win_data, exp_win(0, 0, 130));
      chk("hold_col", win_col, 0);
    end
    win_ready = 1'b1;
    tick();
    win_ready = 1'b0;
    chk("next_fetch_en", rd_en, 1);
    chk("next_fetch_addr", rd_addr, REUSE ? 3 : 1);

    // Random back-pressure and ignored start pulses up to window (5,40).
    cyc = 0;
    while (!(win_valid && win_row == 7'd5 && win_col == 7'd40) && cyc < 20000) begin
      win_ready = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    chk("reach_5_40", cyc < 20000, 1);
    chk("busy_mid_frame", busy, 1);
    start = 1'b0;
    win_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_rd_en", rd_en, 0);
    chk("abort_rd_addr", rd_addr, 0);
    chk("abort_valid", win_valid, 0);
    chkw("abort_data", win_data, '0);
    chk("abort_row", win_row, 0);
    chk("abort_col", win_col, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("no_done_aborted", dn, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_rd_en", rd_en, 1);
    chk("restart_addr", rd_addr, 0);
    win_ready = 1'b1;
    base = hs;
    cyc = 0;
    while (hs < base + 3 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("restart_windows", hs - base, 3);
    win_ready = 1'b0;

    // Whole 8x8 frame with random back-pressure and start pulses while busy.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    cyc = 0;
    while (s_dn == 0 && cyc < 5000) begin
      s_ready = 1'($urandom_range(0, 1));
      s_start = (cyc < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      cyc++;
    end
    s_start = 1'b0;
    s_ready = 1'b0;
    repeat (5) tick();
    chk("frame_windows", s_hs, 64);
    chk("done_pulses", s_dn, 1);
    chk("last_addr", s_max_addr, 99);
    chk("frame_busy", s_busy, 0);
    chk("frame_valid", s_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/padded_window_reader.md
PADDED_WINDOW_READER -- requirements
Module: padded_window_reader

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: begins a frame pass when the block is idle.
REQ-004 SHALL have port rd_en, output, 1 bit: read strobe to the three padded int8 buffers (ch4, ch5, ch6).
REQ-005 SHALL have port rd_addr, output, 15 bits: shared read address, addr = prow*130 + pcol, range 0..16899.
REQ-006 SHALL have ports rd_data_ch4, rd_data_ch5, rd_data_ch6, input, 8 bits signed each: read data, valid exactly 1 cycle after rd_en.
REQ-007 SHALL have port win_valid, output, 1 bit: a 3x3x3 window is presented.
REQ-008 SHALL have port win_ready, input, 1 bit: the consumer accepts the window.
REQ-009 SHALL have port win_data, output, 216 bits: byte (ch*9 + ky*3 + kx) holds the tap; ch 0/1/2 = ch4/ch5/ch6; ky, kx in 0..2.
REQ-010 SHALL have ports win_row and win_col, output, 7 bits each: output pixel coordinate, 0..127.
REQ-011 SHALL have port busy, output, 1 bit, and port done, output, 1 bit: done is a one-cycle end-of-frame pulse.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, CAPTURE, OUT, FIN.
REQ-013 IDLE: start=1 SHALL set row=0, col=0, busy=1, and go to FETCH; start SHALL be ignored in every other state.
REQ-014 FETCH: SHALL assert rd_en for one cycle per tap, with rd_addr = (row+ky)*130 + (col+kx), taps issued in order k = ky*3+kx.
REQ-015 Each read result SHALL be captured into tap register k on the cycle after its issue, via a delayed tap index.
REQ-016 FETCH SHALL last 9 cycles, then CAPTURE for 1 cycle with rd_en=0, then OUT.
REQ-017 OUT: win_valid=1; win_data, win_row and win_col SHALL stay stable until the cycle in which win_ready=1.
REQ-018 The handshake cycle (win_valid & win_ready) SHALL advance col; when col=127, col SHALL wrap to 0 and row SHALL increment.
REQ-019 After the handshake, the FSM SHALL return to FETCH, unless (row,col) was (127,127), in which case it goes to FIN.
REQ-020 FIN: done=1 for exactly one cycle, busy=0, then IDLE.
REQ-021 win_ready asserted while win_valid=0 SHALL have no effect; win_valid SHALL be 0 outside OUT.
REQ-022 Address arithmetic SHALL use 15-bit unsigned values with no truncation; the maximum address is 16899.
REQ-023 Without the macro, latency SHALL be 11 cycles from FETCH entry to win_valid=1, giving 16384 windows per frame.

Reset
REQ-024 On rst, the FSM SHALL go to IDLE.
REQ-025 On rst, rd_en, rd_addr, win_valid, win_data, win_row, win_col, busy and done SHALL all be 0.
REQ-026 On rst, tap registers and row/col counters SHALL be 0.
REQ-027 rst mid-frame SHALL abandon the frame with no done pulse; the next start SHALL restart at (0,0).

Configuration
REQ-028 Macro WINDOW_REUSE_EN: when defined, for col>0 the block SHALL shift taps kx=1,2 into kx=0,1 for all ky and channels.
REQ-029 With WINDOW_REUSE_EN defined, it SHALL then fetch only the 3 taps with kx=2 (ky=0..2), so FETCH lasts 3 cycles.
REQ-030 With WINDOW_REUSE_EN defined, col=0 SHALL still fetch all 9 taps.
REQ-031 Without WINDOW_REUSE_EN, every window SHALL fetch all 9 taps.
REQ-032 win_data contents SHALL be identical with and without WINDOW_REUSE_EN.

Verification
REQ-033 Start pulse, buffer model data = addr[7:0] -> first rd_addr sequence is 0,1,2,130,131,132,260,261,262; win_valid rises 11 cycles after FETCH entry; win_row=0, win_col=0.
REQ-034 win_ready held 0 for 20 cycles in OUT -> win_data and coordinates unchanged, rd_en=0 throughout; win_ready=1 -> next FETCH starts at rd_addr=1.
REQ-035 Full frame with win_ready=1 -> exactly 16384 handshakes; last window taps end at rd_addr 16899; done pulses once; busy falls.
REQ-036 rst asserted during window (5,40) -> all outputs 0 immediately; next start fetches from rd_addr 0; no done from the aborted frame.
REQ-037 WINDOW_REUSE_EN defined, window (0,1) -> only rd_addr 3,133,263 issued; win_data equals the non-reuse golden model.
REQ-038 Start asserted while busy -> ignored; frame count and addresses unaffected.
